// File: rtl/dplca_txop_aging_param_pkg.sv
// dplca_txop_aging_param_pkg: claim/state encodings, on/off constants and claim-table pack helpers
`define DPLCA_TBL_ENT(t, i) t[2*(i) +: 2]
`define DPLCA_TBL_FILL(n, v) {(n){v}}
package dplca_txop_aging_param_pkg;
  typedef enum logic [1:0] {
    CL_SOFT = 2'b00,
    CL_HARD = 2'b01,
    CL_NONE = 2'b10,
    CL_RSVD = 2'b11
  } claim_e;
  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_WAIT     = 3'd1,
    ST_END      = 3'd2,
    ST_UPD      = 3'd3,
    ST_NOTIFY   = 3'd4
  } state_e;
  localparam logic ON = 1'b1;
  localparam logic OFF = 1'b0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
endpackage

// File: rtl/dplca_txop_aging_param_if.sv
// dplca_txop_aging_param_if: aging block control/status bus; event-count signals exist only with DPLCA_AGING_STATS_EN
interface dplca_txop_aging_param_if #(
  parameter int N_ID = 256,
  parameter int ID_W = 8,
  parameter int CNT_W = 16
);
  logic              dplca_aging;
  logic              dplca_txop_end;
  logic [1:0]        dplca_txop_claim;
  logic [ID_W-1:0]   dplca_txop_id;
  logic [CNT_W-1:0]  soft_aging_cycles;
  logic [CNT_W-1:0]  hard_aging_cycles;
  logic [2*N_ID-1:0] txop_claim_table;
  logic [2*N_ID-1:0] txop_claim_table_new;
  logic [2:0]        state;
  logic [CNT_W-1:0]  short_cnt;
  logic [CNT_W-1:0]  long_cnt;
  logic              dplca_new_age;
  logic              dplca_soft_age;
  logic              dplca_txop_table_upd;
`ifdef DPLCA_AGING_STATS_EN
  logic [CNT_W-1:0]  hard_age_events;
  logic [CNT_W-1:0]  soft_age_events;
`endif
  modport master (
`ifdef DPLCA_AGING_STATS_EN
    input  hard_age_events, soft_age_events,
`endif
    output dplca_aging, dplca_txop_end, dplca_txop_claim, dplca_txop_id, soft_aging_cycles, hard_aging_cycles,
    input  txop_claim_table, txop_claim_table_new, state, short_cnt, long_cnt, dplca_new_age, dplca_soft_age,
           dplca_txop_table_upd
  );
  modport slave (
`ifdef DPLCA_AGING_STATS_EN
    output hard_age_events, soft_age_events,
`endif
    input  dplca_aging, dplca_txop_end, dplca_txop_claim, dplca_txop_id, soft_aging_cycles, hard_aging_cycles,
    output txop_claim_table, txop_claim_table_new, state, short_cnt, long_cnt, dplca_new_age, dplca_soft_age,
           dplca_txop_table_upd
  );
endinterface

// File: rtl/dplca_txop_aging_param_claim_table.sv
// dplca_claim_table: N_ID x 2-bit claim registers with HARD-priority write, clear, clear-SOFT and bulk load
module dplca_claim_table
  import dplca_txop_aging_param_pkg::*;
#(
  parameter int N_ID = 256,
  parameter int ID_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              clr_soft,
  input  logic              load,
  input  logic [2*N_ID-1:0] load_tbl,
  input  logic              wr_en,
  input  logic [ID_W-1:0]   wr_idx,
  input  logic [1:0]        wr_claim,
  output logic [2*N_ID-1:0] tbl
);
  logic [2*N_ID-1:0] tbl_q, tbl_d, base;
  always_comb begin
    base = load ? load_tbl : tbl_q;
    tbl_d = base;
    for (int i = 0; i < N_ID; i++)
      `DPLCA_TBL_ENT(tbl_d, i) = (clr || (clr_soft && `DPLCA_TBL_ENT(base, i) == CL_SOFT)) ? CL_NONE :
        (wr_en && wr_idx == ID_W'(i) && !(wr_claim == CL_SOFT && `DPLCA_TBL_ENT(base, i) == CL_HARD)) ? wr_claim :
        `DPLCA_TBL_ENT(base, i);
  end
  always_ff @(posedge clk)
    tbl_q <= reset ? `DPLCA_TBL_FILL(N_ID, CL_NONE) : tbl_d;
  assign tbl = tbl_q;
endmodule

// File: rtl/dplca_txop_aging_param.sv
// dplca_txop_aging_param: DPLCA TXOP claim-aging FSM with soft/hard aging counters (optional DPLCA_AGING_STATS_EN event counts)
module dplca_txop_aging_param
  import dplca_txop_aging_param_pkg::*;
#(
  parameter int N_ID = 256,
  parameter int ID_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  dplca_txop_aging_param_if.slave bus
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  short_q, short_d, long_q, long_d;
  logic              new_age_q, new_age_d, soft_age_q, soft_age_d;
  logic              bnd, hard_fire, soft_fire, is_claim, wr_en, en;
  logic [2*N_ID-1:0] cur_tbl, new_tbl;
  always_comb begin
    en = bus.dplca_aging == ON;
    bnd = state_q == ST_END && bus.dplca_txop_id == '0;
    hard_fire = bnd && long_q >= bus.hard_aging_cycles;
    soft_fire = bnd && short_q >= bus.soft_aging_cycles;
    is_claim = bus.dplca_txop_claim == CL_HARD || bus.dplca_txop_claim == CL_SOFT;
    wr_en = state_q == ST_UPD && is_claim;
    state_d = !en ? ST_DISABLED :
      state_q == ST_DISABLED ? ST_WAIT :
      state_q == ST_WAIT ? (bus.dplca_txop_end ? ST_END : ST_WAIT) :
      state_q == ST_END ? (is_claim ? ST_UPD : ST_NOTIFY) :
      state_q == ST_UPD ? ST_NOTIFY :
      state_q == ST_NOTIFY ? (bus.dplca_txop_end ? ST_NOTIFY : ST_WAIT) : ST_DISABLED;
    long_d = (!en || hard_fire) ? '0 : (bnd && !(&long_q)) ? long_q + 1'b1 : long_q;
    short_d = (!en || soft_fire) ? '0 : (bnd && !(&short_q)) ? short_q + 1'b1 : short_q;
    new_age_d = !en ? OFF : state_q == ST_END ? hard_fire :
      (state_q == ST_NOTIFY && !bus.dplca_txop_end) ? OFF : new_age_q;
    soft_age_d = !en ? OFF : state_q == ST_END ? soft_fire :
      (state_q == ST_NOTIFY && !bus.dplca_txop_end) ? OFF : soft_age_q;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? ST_DISABLED : state_d;
    long_q <= reset ? '0 : long_d;
    short_q <= reset ? '0 : short_d;
    new_age_q <= reset ? OFF : new_age_d;
    soft_age_q <= reset ? OFF : soft_age_d;
  end
  dplca_claim_table #(.N_ID(N_ID), .ID_W(ID_W)) u_cur (
    .clk(clk), .reset(reset), .clr(!en), .clr_soft(soft_fire), .load(hard_fire), .load_tbl(new_tbl),
    .wr_en(wr_en), .wr_idx(bus.dplca_txop_id), .wr_claim(bus.dplca_txop_claim), .tbl(cur_tbl)
  );
  dplca_claim_table #(.N_ID(N_ID), .ID_W(ID_W)) u_new (
    .clk(clk), .reset(reset), .clr(!en || hard_fire), .clr_soft(OFF), .load(OFF), .load_tbl('0),
    .wr_en(wr_en), .wr_idx(bus.dplca_txop_id), .wr_claim(bus.dplca_txop_claim), .tbl(new_tbl)
  );
`ifdef DPLCA_AGING_STATS_EN
  logic [CNT_W-1:0] hard_ev_q, hard_ev_d, soft_ev_q, soft_ev_d;
  always_comb begin
    hard_ev_d = !en ? '0 : (hard_fire && !(&hard_ev_q)) ? hard_ev_q + 1'b1 : hard_ev_q;
    soft_ev_d = !en ? '0 : (soft_fire && !(&soft_ev_q)) ? soft_ev_q + 1'b1 : soft_ev_q;
  end
  always_ff @(posedge clk) begin
    hard_ev_q <= reset ? '0 : hard_ev_d;
    soft_ev_q <= reset ? '0 : soft_ev_d;
  end
  assign bus.hard_age_events = hard_ev_q;
  assign bus.soft_age_events = soft_ev_q;
`endif
  assign bus.txop_claim_table = cur_tbl;
  assign bus.txop_claim_table_new = new_tbl;
  assign bus.state = state_q;
  assign bus.short_cnt = short_q;
  assign bus.long_cnt = long_q;
  assign bus.dplca_new_age = new_age_q;
  assign bus.dplca_soft_age = soft_age_q;
  assign bus.dplca_txop_table_upd = state_q == ST_NOTIFY;
endmodule

// File: doc/dplca_txop_aging_param.md
Name: dplca_txop_aging_param

Overview:
Parametrised, clocked successor of the DPLCA TXOP claim-aging state diagram. It owns the current and new TXOP claim tables as registers. It applies HARD and SOFT claims reported at each TXOP end, and ages entries on two independent timescales: soft aging clears SOFT entries, and hard aging swaps the new table into the current one. It sits beside the PLCA control/DPLCA claim logic and feeds the claim table and update strobes back to it.

Parameters:
N_ID, 256, number of TXOP IDs tracked (table depth), 2..256
ID_W, 8, width of dplca_txop_id; must satisfy 2^ID_W >= N_ID
CNT_W, 16, width of aging counters and aging thresholds

Ports:
clk  input  1  block clock
reset  input  1  synchronous, active-high reset
dplca_aging  input  1  aging enable; 0 forces DISABLED
dplca_txop_end  input  1  level, high while a TXOP has ended
dplca_txop_claim  input  2  claim result: SOFT=2'b00, HARD=2'b01, NONE=2'b10, 2'b11 treated as NONE
dplca_txop_id  input  ID_W  ID of the ended TXOP
soft_aging_cycles  input  CNT_W  soft aging threshold, in PLCA cycles
hard_aging_cycles  input  CNT_W  hard aging threshold, in PLCA cycles
txop_claim_table  output  2*N_ID  current table; entry i occupies bits [2i+1:2i]
txop_claim_table_new  output  2*N_ID  table being rebuilt for the next hard age
state  output  3  DISABLED=0, WAIT_TXOP_END=1, TXOP_END=2, UPDATE_CLAIM=3, NOTIFY=4
short_cnt  output  CNT_W  soft aging counter
long_cnt  output  CNT_W  hard aging counter
dplca_new_age  output  1  a hard age occurred in the current TXOP
dplca_soft_age  output  1  a soft age occurred in the current TXOP
dplca_txop_table_upd  output  1  table update notification

Behaviour:
- Reset is synchronous and active-high. All registers update on the rising edge of clk; one state transition per clock.
- Reset, or dplca_aging==0 in any state, forces the following on the next edge:
  - state=DISABLED
  - both tables all NONE (2'b10)
  - short_cnt=long_cnt=0
  - all flags 0
- DISABLED -> WAIT_TXOP_END unconditionally when dplca_aging=1.
- WAIT_TXOP_END:
  - new_age, soft_age and table_upd are 0.
  - Go to TXOP_END when dplca_txop_end=1.
- TXOP_END entry actions, applied only if dplca_txop_id==0 (cycle boundary):
  - Hard age: if long_cnt >= hard_aging_cycles, then txop_claim_table <= txop_claim_table_new, new table <= all NONE, long_cnt <= 0, new_age <= 1. Otherwise long_cnt <= long_cnt+1.
  - Soft age: if short_cnt >= soft_aging_cycles, then every SOFT entry becomes NONE, short_cnt <= 0, soft_age <= 1. Otherwise short_cnt <= short_cnt+1.
  - When both fire in the same TXOP, soft clearing applies to the post-swap table, and the new table is all NONE.
  - Using >= means a threshold lowered below the current count fires at the next boundary.
  - A threshold of 0 ages at every boundary.
- TXOP_END exits:
  - claim HARD or SOFT -> UPDATE_CLAIM
  - claim NONE or 2'b11 -> NOTIFY
- UPDATE_CLAIM:
  - IDs >= N_ID: no write, but the state still proceeds.
  - HARD: write HARD at id in both tables.
  - SOFT: write SOFT at id in each table only where that table's entry is not HARD.
  - -> NOTIFY.
- NOTIFY: table_upd=1, held until dplca_txop_end=0, then -> WAIT_TXOP_END.
- Flag latency: new_age and soft_age are visible the cycle after TXOP_END is entered, and held through NOTIFY.
- Counters never wrap silently. They reset on age, so they are bounded by threshold+1 unless the threshold is at all-ones, in which case they saturate at all-ones.

Optional Feature:
DPLCA_AGING_STATS_EN:
- Defined: adds outputs hard_age_events and soft_age_events (each CNT_W, saturating). Each increments once per respective age event and is cleared on reset or dplca_aging==0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - claim encodings SOFT/HARD/NONE
  - state encodings
  - ON/OFF and TRUE/FALSE constants
  - table-pack/unpack helper macros
- One sub-module, dplca_claim_table: a parametrised N_ID x 2-bit register array with:
  - a single-entry write port with HARD-priority rule
  - bulk clear-to-NONE
  - bulk clear-SOFT
  - bulk load from another table
- It is instantiated twice (current and new); the FSM and counters stay in the top level.

Test Plan:
- Reset then aging=1 -> DISABLED then WAIT_TXOP_END; both tables all 2'b10; counters 0.
- id=5, claim HARD, txop_end pulse 3 cycles -> entry 5 = HARD in both tables, table_upd=1 until txop_end falls, state returns to 1.
- hard_aging_cycles=2; 3 boundary TXOPs (id=0, claim NONE) after entry 7 is claimed HARD -> third boundary: new_age=1, current entry 7 HARD (from new), new table all NONE, long_cnt=0.
- soft_aging_cycles=1, entry 3 SOFT and entry 4 HARD -> second boundary: entry 3 NONE, entry 4 HARD, soft_age=1; SOFT claim on a HARD entry leaves it HARD.
- Both thresholds 0 with id=0, claim SOFT -> both ages fire in TXOP_END, then UPDATE_CLAIM writes SOFT at entry 0 in both tables.
- aging dropped during UPDATE_CLAIM -> next cycle DISABLED, tables cleared, flags 0; id=N_ID with claim HARD -> no write, NOTIFY still occurs.
